// File: rtl/image_frame_sequencer.sv
// Frame sequencer: walks one image as pixel pairs, reads a synchronous pair memory,
// and streams row/col-tagged pairs through a 2-entry first-word-fall-through skid FIFO.
module image_frame_sequencer #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int ADDR_W = 17,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_workflow,
    input  logic [2:0]        cfg_operation,
    input  logic [31:0]       cfg_value,
    input  logic              cfg_sign,
    output logic              op_workflow,
    output logic [2:0]        op_operation,
    output logic [31:0]       op_value,
    output logic              op_sign,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [47:0]       rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [47:0]       pix_data,
    output logic [ROW_W-1:0]  pix_row,
    output logic [COL_W-1:0]  pix_col,
    output logic              pix_last
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int                NPAIRS    = WIDTH * HEIGHT / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPAIRS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;

    logic              vld_p1;
    logic [ROW_W-1:0]  row_p1;
    logic [COL_W-1:0]  col_p1;
    logic              last_p1;

    logic [47:0]       fifo_data [2];
    logic [ROW_W-1:0]  fifo_row  [2];
    logic [COL_W-1:0]  fifo_col  [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;

    logic              pop, issue, accept, reject, cfg_error_r;
    logic [2:0]        pending;

    // Occupancy after this cycle's pop, counting the read whose data lands at the next edge
    always_comb begin
        pop     = (count != 2'd0) && pix_ready;
        pending = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
        issue   = (state == FETCH) && !abort && (pending < 3'd2);
        accept  = (state == IDLE) && start && !abort && (cfg_operation <= 3'd5);
        reject  = (state == IDLE) && start && !abort && (cfg_operation > 3'd5);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   if (issue && addr_cnt == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (pending == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Control path
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= IDLE;
            addr_cnt     <= '0;
            row_cnt      <= '0;
            col_cnt      <= '0;
            vld_p1       <= 1'b0;
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            cfg_error_r  <= 1'b0;
            op_workflow  <= 1'b0;
            op_operation <= 3'd0;
            op_value     <= 32'd0;
            op_sign      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_error_r <= reject;
            if (accept) begin
                op_workflow  <= cfg_workflow;
                op_operation <= cfg_operation;
                op_value     <= cfg_value;
                op_sign      <= cfg_sign;
                addr_cnt     <= '0;
                row_cnt      <= '0;
                col_cnt      <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
                if (col_cnt == LAST_COL) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(2);
                end
            end
            if (abort) begin
                vld_p1 <= 1'b0;
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                vld_p1 <= issue;
                if (vld_p1) wr_ptr <= ~wr_ptr;
                if (pop)    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, vld_p1} - {1'b0, pop};
            end
        end
    end

    // Stage p1: tag travels with the outstanding read; FIFO entry written when data returns
    always_ff @(posedge HCLK) begin
        if (issue) begin
            row_p1  <= row_cnt;
            col_p1  <= col_cnt;
            last_p1 <= (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
        end
        if (vld_p1) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_row[wr_ptr]  <= row_p1;
            fifo_col[wr_ptr]  <= col_p1;
            fifo_last[wr_ptr] <= last_p1;
        end
    end

    // Payload is forced to zero while empty so stale entries never reach the stream
    always_comb begin
        pix_valid  = (count != 2'd0);
        pix_data   = pix_valid ? fifo_data[rd_ptr] : 48'd0;
        pix_row    = pix_valid ? fifo_row[rd_ptr]  : '0;
        pix_col    = pix_valid ? fifo_col[rd_ptr]  : '0;
        pix_last   = pix_valid && fifo_last[rd_ptr];
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        cfg_error  = cfg_error_r;
        rd_en      = issue;
        rd_addr    = addr_cnt;
    end

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed bench for image_frame_sequencer on an 8x4 image with a synchronous pair-memory model
// and a scoreboard of expected pairs filled at each accepted start.
module tb_image_frame_sequencer;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int ADDR_W = 4;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 4;
    localparam int NPAIRS = WIDTH * HEIGHT / 2;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              cfg_workflow = 1'b0;
    logic [2:0]        cfg_operation = 3'd0;
    logic [31:0]       cfg_value = 32'd0;
    logic              cfg_sign = 1'b0;
    logic              op_workflow;
    logic [2:0]        op_operation;
    logic [31:0]       op_value;
    logic              op_sign;
    logic              busy, frame_done, cfg_error, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [47:0]       rd_data;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [47:0]       pix_data;
    logic [ROW_W-1:0]  pix_row;
    logic [COL_W-1:0]  pix_col;
    logic              pix_last;

    typedef struct packed {
        logic [47:0]      data;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } pair_t;

    pair_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 HCLK = ~HCLK;

    image_frame_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .cfg_workflow(cfg_workflow), .cfg_operation(cfg_operation),
        .cfg_value(cfg_value), .cfg_sign(cfg_sign),
        .op_workflow(op_workflow), .op_operation(op_operation),
        .op_value(op_value), .op_sign(op_sign),
        .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last)
    );

    function automatic logic [47:0] mem_word(input logic [ADDR_W-1:0] a);
        return {12{a}} ^ 48'h1234_5678_9ABC;
    endfunction

    // Synchronous pair memory: data valid the cycle after rd_en
    always @(posedge HCLK) begin
        if (rd_en) rd_data <= mem_word(rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        pair_t p;
        for (int a = 0; a < NPAIRS; a++) begin
            p.data = mem_word(ADDR_W'(a));
            p.row  = ROW_W'(a / (WIDTH / 2));
            p.col  = COL_W'((a % (WIDTH / 2)) * 2);
            p.last = (a == NPAIRS - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic do_start(input logic wf, input logic [2:0] op, input logic [31:0] val,
                            input logic sg);
        @(negedge HCLK);
        start = 1'b1; cfg_workflow = wf; cfg_operation = op; cfg_value = val; cfg_sign = sg;
        if (op <= 3'd5) push_frame();
    endtask

    // mode 0: pix_ready high; mode 1: ready pattern 1,0,0,1
    task automatic run_frame(input int mode, input int abort_after, input int inject_k);
        int    k = 0, accepted = 0, issued = 0, exp_addr = 0;
        int    done_cnt = 0, done_k = 0, first_valid_k = 0, abort_k = 0;
        logic  pv_prev = 1'b0, pr_prev = 1'b0, hs;
        pair_t held, got, exp;
        bit    fin = 1'b0;
        while (!fin) begin
            @(negedge HCLK);
            k++;
            start = (k == inject_k);
            if (k == inject_k) begin cfg_value = 32'd7; cfg_operation = 3'd4; end
            abort = 1'b0;
            if (abort_after > 0 && accepted == abort_after && abort_k == 0) begin
                abort = 1'b1; abort_k = k;
            end
            pix_ready = (mode == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
            #1;
            if (k == 1) begin
                chk("busy_after_start", 64'(busy), 64'(1));
                chk("rd_en_after_start", 64'(rd_en), 64'(1));
                chk("rd_addr_first", 64'(rd_addr), 64'(0));
            end
            if (abort_k != 0 && k > abort_k) begin
                if (k == abort_k + 1) chk("busy_after_abort", 64'(busy), 64'(0));
                chk("pix_valid_after_abort", 64'(pix_valid), 64'(0));
                chk("frame_done_after_abort", 64'(frame_done), 64'(0));
                if (k == abort_k + 4) fin = 1'b1;
            end else begin
                hs  = pix_valid && pix_ready;
                got = '{pix_data, pix_row, pix_col, pix_last};
                if (pv_prev && !pr_prev) begin
                    chk("stall_valid_held", 64'(pix_valid), 64'(1));
                    chk("stall_payload_held", 64'(got), 64'(held));
                end
                if (rd_en) begin
                    chk("rd_addr_order", 64'(rd_addr), 64'(exp_addr));
                    chk("outstanding_limit", 64'(issued - accepted - int'(hs) < 2), 64'(1));
                    issued++; exp_addr++;
                end
                if (pix_valid && first_valid_k == 0) first_valid_k = k;
                if (hs) begin
                    chk("pair_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        chk("pix_data", 64'(got.data), 64'(exp.data));
                        chk("pix_row_col", 64'({got.row, got.col}), 64'({exp.row, exp.col}));
                        chk("pix_last", 64'(got.last), 64'(exp.last));
                    end
                    accepted++;
                end
                if (frame_done) begin done_cnt++; done_k = k; end
                if (done_k != 0 && k == done_k + 1) begin
                    chk("busy_after_done", 64'(busy), 64'(0));
                    fin = 1'b1;
                end
                pv_prev = pix_valid; pr_prev = pix_ready; held = got;
            end
            if (!fin && k >= 400) begin
                chk("frame_timeout_cycles", 64'(k), 64'(done_k + 1));
                fin = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0;
        if (abort_after == 0) begin
            chk("frame_done_count", 64'(done_cnt), 64'(1));
            chk("pairs_accepted", 64'(accepted), 64'(NPAIRS));
            chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
            if (mode == 0) begin
                chk("frame_done_cycle", 64'(done_k), 64'(3 + NPAIRS));
                chk("first_valid_cycle", 64'(first_valid_k), 64'(3));
            end
        end else begin
            chk("no_done_on_abort", 64'(done_cnt), 64'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rd", 64'({rd_en, rd_addr}), 64'(0));
        chk("reset_pix", 64'({pix_valid, pix_data, pix_row, pix_col, pix_last}), 64'(0));
        chk("reset_op", 64'({op_workflow, op_operation, op_value, op_sign}), 64'(0));
        chk("reset_pulses", 64'({frame_done, cfg_error}), 64'(0));

        // Full frame, ready always high
        do_start(1'b1, 3'd2, 32'd90, 1'b1);
        run_frame(0, 0, 0);
        chk("op_latched", 64'({op_workflow, op_operation, op_value, op_sign}),
            64'({1'b1, 3'd2, 32'd90, 1'b1}));

        // Backpressure pattern
        do_start(1'b0, 3'd2, 32'd90, 1'b0);
        run_frame(1, 0, 0);

        // Illegal operation code
        do_start(1'b1, 3'd6, 32'd55, 1'b1);
        @(negedge HCLK); start = 1'b0; #1;
        chk("cfg_error_pulse", 64'(cfg_error), 64'(1));
        chk("busy_on_reject", 64'(busy), 64'(0));
        @(negedge HCLK); #1;
        chk("cfg_error_one_cycle", 64'(cfg_error), 64'(0));
        chk("op_kept_on_reject", 64'({op_operation, op_value}), 64'({3'd2, 32'd90}));

        // Abort after 5 pairs, then fresh frame
        do_start(1'b0, 3'd3, 32'd11, 1'b0);
        run_frame(0, 5, 0);
        chk("op_kept_on_abort", 64'(op_value), 64'(11));
        do_start(1'b0, 3'd1, 32'd22, 1'b1);
        run_frame(0, 0, 0);

        // Start during FETCH is ignored
        do_start(1'b0, 3'd1, 32'd22, 1'b1);
        run_frame(0, 0, 4);
        chk("op_kept_on_busy_start", 64'({op_operation, op_value}), 64'({3'd1, 32'd22}));
        chk("no_cfg_error_busy_start", 64'(cfg_error), 64'(0));

        // Reset mid-frame with a pair pending
        do_start(1'b1, 3'd5, 32'd33, 1'b1);
        @(negedge HCLK); start = 1'b0; pix_ready = 1'b0;
        repeat (2) @(negedge HCLK);
        #1;
        chk("valid_before_reset", 64'(pix_valid), 64'(1));
        @(negedge HCLK); HRESET = 1'b1;
        @(negedge HCLK); HRESET = 1'b0; #1;
        exp_q.delete();
        chk("midreset_ctrl", 64'({busy, frame_done, cfg_error, rd_en, rd_addr}), 64'(0));
        chk("midreset_pix", 64'({pix_valid, pix_data, pix_row, pix_col, pix_last}), 64'(0));
        chk("midreset_op", 64'({op_workflow, op_operation, op_value, op_sign}), 64'(0));

        // Normal frame after reset
        do_start(1'b0, 3'd0, 32'd44, 1'b0);
        run_frame(1, 0, 0);
        chk("op_after_reset_frame", 64'(op_value), 64'(44));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
